// File: rtl/seletor_funcionalidade_debounce.sv
// seletor_funcionalidade_debounce: sync, debounce and one-hot latch of 7 button lines.
// Optional: CLEAR_ON_ERR_EN clears sel/sel_valid when a multi-press is rejected.
module seletor_funcionalidade_debounce #(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] btn,
   output logic [6:0] sel,
   output logic       sel_valid,
   output logic       new_sel,
   output logic       err_multi
);
   typedef enum logic [1:0] {IDLE, CHECK, RELEASE} state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
   state_t state, state_n;
   logic [6:0] meta, sync, cand, cand_n, sel_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic sel_valid_n, new_sel_n, err_multi_n, one_hot, last;
   assign one_hot = (cand != 7'd0) && ((cand & (cand - 7'd1)) == 7'd0);
   assign last    = cnt == LAST;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta      <= '0;
         sync      <= '0;
         state     <= IDLE;
         cnt       <= '0;
         cand      <= '0;
         sel       <= '0;
         sel_valid <= 1'b0;
         new_sel   <= 1'b0;
         err_multi <= 1'b0;
      end else begin
         meta      <= btn;
         sync      <= meta;
         state     <= state_n;
         cnt       <= cnt_n;
         cand      <= cand_n;
         sel       <= sel_n;
         sel_valid <= sel_valid_n;
         new_sel   <= new_sel_n;
         err_multi <= err_multi_n;
      end
   end
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      cand_n      = cand;
      sel_n       = sel;
      sel_valid_n = sel_valid;
      new_sel_n   = 1'b0;
      err_multi_n = 1'b0;
      case (state)
         IDLE:
            if (sync != 7'd0) begin
               cand_n  = sync;
               cnt_n   = '0;
               state_n = CHECK;
            end
         CHECK:
            if (sync != cand) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else if (last) begin
               cnt_n   = '0;
               state_n = RELEASE;
               if (one_hot) begin
                  sel_n       = cand;
                  sel_valid_n = 1'b1;
                  new_sel_n   = 1'b1;
               end else begin
                  err_multi_n = 1'b1;
`ifdef CLEAR_ON_ERR_EN
                  sel_n       = '0;
                  sel_valid_n = 1'b0;
`else
                  sel_n       = sel;
                  sel_valid_n = sel_valid;
`endif
               end
            end else begin
               cnt_n = cnt + ONE;
            end
         RELEASE:
            // any non-zero sample restarts the release window
            if (sync != 7'd0) begin
               cnt_n = '0;
            end else if (last) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + ONE;
            end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_seletor_funcionalidade_debounce.sv
// tb_seletor_funcionalidade_debounce: per-edge vector table plus async reset sequence.
module tb_seletor_funcionalidade_debounce;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] btn = '0;
   logic [6:0] sel;
   logic       sel_valid, new_sel, err_multi;
   int pass_cnt = 0;
   int total = 0;
   typedef struct {
      logic       r;
      logic [6:0] b;
      logic [6:0] s;
      logic       v, n, e;
   } vec_t;
   vec_t vq[$];
   localparam logic [6:0] A = 7'b1000000, B = 7'b0100000, C = 7'b0010000;
   localparam logic [6:0] G = 7'b0000001, M = 7'b1000001;
   seletor_funcionalidade_debounce dut (
      .clk(clk), .reset(reset), .btn(btn), .sel(sel),
      .sel_valid(sel_valid), .new_sel(new_sel), .err_multi(err_multi)
   );
   always #5 clk = ~clk;
   function automatic void add(logic r, logic [6:0] b, logic [6:0] s, logic v, logic n, logic e);
      vq.push_back('{r, b, s, v, n, e});
   endfunction
   function automatic void rep(int k, logic [6:0] b, logic [6:0] s, logic v);
      for (int i = 0; i < k; i++) add(1'b0, b, s, v, 1'b0, 1'b0);
   endfunction
   // press held from idle: accepted on the 7th edge, one held edge, then a full release
   function automatic void press(logic [6:0] b, logic [6:0] s0, logic v0,
                                 logic [6:0] s1, logic v1, logic n, logic e);
      rep(6, b, s0, v0);
      add(1'b0, b, s1, v1, n, e);
      add(1'b0, b, s1, v1, 1'b0, 1'b0);
      rep(6, 7'd0, s1, v1);
   endfunction
   task automatic check(string name, logic [9:0] act, logic [9:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got sel/valid/new/err=%b required %b", name, act, exp);
   endtask
   initial begin
      logic [6:0] es;
      logic       ev;
`ifdef CLEAR_ON_ERR_EN
      es = 7'd0;
      ev = 1'b0;
`else
      es = G;
      ev = 1'b1;
`endif
      add(1'b1, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
      add(1'b1, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
      rep(6, C, 7'd0, 1'b0);
      add(1'b0, C, C, 1'b1, 1'b1, 1'b0);
      add(1'b0, C, C, 1'b1, 1'b0, 1'b0);
      rep(2, 7'd0, C, 1'b1);
      rep(2, G, C, 1'b1);
      rep(6, 7'd0, C, 1'b1);
      press(G, C, 1'b1, G, 1'b1, 1'b1, 1'b0);
      add(1'b1, 7'd0, 7'd0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) rep(1, ((i / 2) % 2 == 0) ? 7'd1 : 7'd0, 7'd0, 1'b0);
      rep(6, 7'd0, 7'd0, 1'b0);
      press(G, 7'd0, 1'b0, G, 1'b1, 1'b1, 1'b0);
      press(M, G, 1'b1, es, ev, 1'b0, 1'b1);
      rep(6, B, es, ev);
      add(1'b0, B, B, 1'b1, 1'b1, 1'b0);
      add(1'b0, B, B, 1'b1, 1'b0, 1'b0);
      rep(1, 7'd0, B, 1'b1);
      rep(3, B, B, 1'b1);
      rep(6, 7'd0, B, 1'b1);
      press(B, B, 1'b1, B, 1'b1, 1'b1, 1'b0);
      foreach (vq[i]) begin
         @(negedge clk);
         reset = vq[i].r;
         btn   = vq[i].b;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), {sel, sel_valid, new_sel, err_multi},
               {vq[i].s, vq[i].v, vq[i].n, vq[i].e});
      end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         btn = A;
         @(posedge clk);
         #1;
         check($sformatf("hold_a%0d", k), {sel, sel_valid, new_sel, err_multi}, {B, 3'b100});
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("async_reset", {sel, sel_valid, new_sel, err_multi}, 10'd0);
      @(posedge clk);
      #1;
      check("reset_edge", {sel, sel_valid, new_sel, err_multi}, 10'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("after_reset%0d", k), {sel, sel_valid, new_sel, err_multi},
               (k < 7) ? 10'd0 : {A, 1'b1, k == 7, 1'b0});
      end
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
